lbist_ctrl: RTL and testbench
=============================

# lbist_ctrl

Sequencer for the LBIST mid section. It starts the fault-injection campaign, steps the fault injection logic one fault at a time through its `FIL_INC`/`FIL_END` pair, and applies a reseeded pseudo-random pattern set to both CUTs for each fault. It compares the faulty and fault-free outputs and accumulates the total-fault and detected-fault counts that give fault coverage. It sits between the test top level and the mid section, driving `TEST_IP` and `FIL_INC` and consuming `CUT_OP`, `FF_OP` and `FIL_END`.

## Interface
Parameters:
- `IN_BITS`, 33, pattern width (CUT input count)
- `OUT_BITS`, 25, CUT output count
- `PAT_CNT`, 256, patterns applied per fault (≥1)
- `CNT_W`, 16, width of fault counters
- `TAPS`, 33'h1_0008_0000 (bits 32, 19), LFSR feedback mask
- `SEED`, 1, LFSR seed; a value of 0 is replaced by 1

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset; it is also the reset of the mid-section FIL
- `start`  in  1  level; sampled only in IDLE/DONE
- `busy`  out  1  campaign in progress
- `done`  out  1  campaign complete; holds until next `start`
- `fil_inc`  out  1  to `FIL_INC`; one-cycle pulse per fault
- `fil_end`  in  1  from `FIL_END`; high means the currently injected fault is the last one
- `test_ip`  out  IN_BITS  to `TEST_IP`; registered
- `cut_op`  in  OUT_BITS  faulty CUT output
- `ff_op`  in  OUT_BITS  fault-free CUT output
- `fault_cnt`  out  CNT_W  faults applied
- `detect_cnt`  out  CNT_W  faults with at least one mismatch
- `mismatch`  out  1  registered: `cut_op != ff_op` in the previous APPLY cycle

## Operation
- States: IDLE, INJECT, SETTLE, APPLY, NEXT, DONE.
- IDLE/DONE, `start`=1: clear both counters and `done`, then go to INJECT.
- INJECT (1 cycle):
  - `fil_inc`=1.
  - LFSR ← SEED, pattern index ← 0, detect flag ← 0.
  - Go to SETTLE.
- SETTLE (1 cycle): `test_ip` ← LFSR, LFSR steps. Go to APPLY.
- APPLY (PAT_CNT cycles):
  - Each cycle, `cut_op`/`ff_op` are compared against the `test_ip` currently driven.
  - On mismatch, detect flag ← 1.
  - `test_ip` ← LFSR, LFSR steps, index increments.
  - When index = PAT_CNT−1, go to NEXT.
- NEXT (1 cycle):
  - `fault_cnt` += 1; `detect_cnt` += detect flag.
  - If `fil_end`=1, go to DONE; otherwise go to INJECT.
- DONE: `done`=1, `busy`=0.
- LFSR is Fibonacci: new LSB = XOR-reduce(state & TAPS), shifted left. Every fault sees an identical pattern sequence.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- Invariant: `detect_cnt` ≤ `fault_cnt`.
- `start` while busy is ignored.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `fil_inc`, `mismatch` = 0.
  - `test_ip` = 0.
  - `fault_cnt`, `detect_cnt` = 0.
- `busy`=1 in every state except IDLE/DONE.
- Cycles per fault = PAT_CNT + 3 (INJECT + SETTLE + APPLY + NEXT).
- The FIL injects its new fault on the `clk` edge where it samples `fil_inc`=1. SETTLE guarantees that edge precedes the first compared pattern.
- `fil_end` is sampled only in NEXT.
- Reset mid-campaign: return immediately to IDLE with all outputs at reset values. The FIL restarts its fault list, since it shares `rst`.
- `start` and `rst` deasserting in the same cycle: `start` is seen on the first clock after release.

## Configuration
- Macro: `LBIST_EARLY_EXIT_EN`.
- Defined: an APPLY-cycle mismatch sets the flag and jumps straight to NEXT. The remaining patterns for that fault are skipped.
- Undefined: all PAT_CNT patterns are always applied. The counters are identical either way; only the cycle count differs.

## Structure
- Package `lbist_pkg`:
  - state enum `lbist_state_t`
  - default `TAPS`/`SEED` constants for 33 bits
  - helper constant for the index width, `$clog2(PAT_CNT)`
- Sub-module `lbist_lfsr`:
  - parameters: width, taps, seed
  - ports: `load`, `step`, `q`
- The controller FSM and counters stay in `lbist_ctrl`.

## Test plan
- Fault-free stub (`cut_op`=`ff_op`), FIL model with 4 faults and `fil_end` on the 4th, PAT_CNT=8 → `fault_cnt`=4, `detect_cnt`=0, `done` after 4×11 cycles, exactly 4 `fil_inc` pulses.
- Stub flips `cut_op[0]` for faults 1 and 3 on pattern 5 only → `detect_cnt`=2, `fault_cnt`=4.
- Same as above with `LBIST_EARLY_EXIT_EN` → the same counts; the per-fault cycle count drops from 11 to 8 for the detected faults.
- `rst` low during APPLY of fault 2 → next cycle all outputs are 0 and state is IDLE; a restarted campaign reproduces the counts of the first scenario.
- CNT_W=2 with 6 faults, all detected → both counters saturate at 3.
- Check the `test_ip` sequence against a reference LFSR model. SEED=0 must yield a first pattern with the seed 1 shifted once, and the sequence must be identical for every fault.

Source files
------------

// File: rtl/lbist_pkg.sv
// Shared types and constants for the LBIST mid-section sequencer.
package lbist_pkg;

   // Controller phases; the controller keeps the encoding as plain 3-bit constants
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INJECT = 3'd1,
      ST_SETTLE = 3'd2,
      ST_APPLY  = 3'd3,
      ST_NEXT   = 3'd4,
      ST_DONE   = 3'd5
   } lbist_state_t;

   // Default 33-bit LFSR feedback (bits 32 and 19) and seed
   localparam logic [32:0] DEF_TAPS = 33'h1_0008_0000;
   localparam logic [32:0] DEF_SEED = 33'd1;

   // Pattern index width; a single-pattern campaign still needs one bit
   function automatic int idx_width(input int pat_cnt);
      return (pat_cnt > 1) ? $clog2(pat_cnt) : 1;
   endfunction

endpackage

// File: rtl/lbist_ctrl_if.sv
// Handshake/data bundle between the LBIST sequencer (master) and the
// test top level plus mid section (slave).
interface lbist_ctrl_if #(
   parameter int IN_BITS  = 33,
   parameter int OUT_BITS = 25,
   parameter int CNT_W    = 16
);
   logic                start;
   logic                busy;
   logic                done;
   logic                fil_inc;
   logic                fil_end;
   logic [IN_BITS-1:0]  test_ip;
   logic [OUT_BITS-1:0] cut_op;
   logic [OUT_BITS-1:0] ff_op;
   logic [CNT_W-1:0]    fault_cnt;
   logic [CNT_W-1:0]    detect_cnt;
   logic                mismatch;

   modport master (
      input  start, fil_end, cut_op, ff_op,
      output busy, done, fil_inc, test_ip, fault_cnt, detect_cnt, mismatch
   );

   modport slave (
      output start, fil_end, cut_op, ff_op,
      input  busy, done, fil_inc, test_ip, fault_cnt, detect_cnt, mismatch
   );
endinterface

// File: rtl/lbist_lfsr.sv
// Fibonacci LFSR pattern source: new LSB = XOR of tapped bits, shift left.
// Resets to zero (so the driven pattern is zero out of reset); a load is
// always issued before stepping. A zero seed is replaced by 1.
module lbist_lfsr #(
   parameter int               WIDTH = 33,
   parameter logic [WIDTH-1:0] TAPS  = '1,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   output logic [WIDTH-1:0] q
);
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

   logic [WIDTH-1:0] state;

   // Load has priority over step so every fault restarts the same sequence
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= '0;
      else if (load)
         state <= SEED_EFF;
      else if (step)
         state <= {state[WIDTH-2:0], ^(state & TAPS)};
   end

   assign q = state;
endmodule

// File: rtl/lbist_ctrl.sv
// LBIST fault-injection campaign sequencer.
// Per fault: INJECT (pulse fil_inc, reload LFSR) -> SETTLE -> APPLY x PAT_CNT
// -> NEXT (update saturating counters, test fil_end).
// Optional macro LBIST_EARLY_EXIT_EN: leave APPLY on the first mismatch.
module lbist_ctrl
   import lbist_pkg::*;
#(
   parameter int                 IN_BITS  = 33,
   parameter int                 OUT_BITS = 25,
   parameter int                 PAT_CNT  = 256,
   parameter int                 CNT_W    = 16,
   parameter logic [IN_BITS-1:0] TAPS     = IN_BITS'(DEF_TAPS),
   parameter logic [IN_BITS-1:0] SEED     = IN_BITS'(DEF_SEED)
) (
   input logic         clk,
   input logic         rst,
   lbist_ctrl_if.master bus
);
   localparam int               IDX_W    = idx_width(PAT_CNT);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_CNT - 1);

   localparam logic [2:0] IDLE   = ST_IDLE;
   localparam logic [2:0] INJECT = ST_INJECT;
   localparam logic [2:0] SETTLE = ST_SETTLE;
   localparam logic [2:0] APPLY  = ST_APPLY;
   localparam logic [2:0] NEXT   = ST_NEXT;
   localparam logic [2:0] DONE   = ST_DONE;

   logic [2:0]          state;
   logic [IDX_W-1:0]    idx;
   logic                detect;
   logic [CNT_W-1:0]    fault_cnt;
   logic [CNT_W-1:0]    detect_cnt;
   logic                mismatch;
   logic [OUT_BITS-1:0] op_xor;
   logic                diff;
   logic                lfsr_load;
   logic                lfsr_step;
   logic [IN_BITS-1:0]  pattern;

   assign op_xor    = bus.cut_op ^ bus.ff_op;
   assign diff      = |op_xor;
   assign lfsr_load = (state == INJECT);
   assign lfsr_step = (state == SETTLE) || (state == APPLY);

   // The LFSR register itself drives test_ip: SETTLE steps it once past the
   // seed, so the first compared pattern is the seed shifted once
   lbist_lfsr #(
      .WIDTH (IN_BITS),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (lfsr_load),
      .step (lfsr_step),
      .q    (pattern)
   );

   // Campaign FSM, pattern index, per-fault detect flag and saturating counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         idx        <= '0;
         detect     <= 1'b0;
         fault_cnt  <= '0;
         detect_cnt <= '0;
         mismatch   <= 1'b0;
      end else begin
         mismatch <= (state == APPLY) && diff;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  fault_cnt  <= '0;
                  detect_cnt <= '0;
                  state      <= INJECT;
               end
            end
            INJECT: begin
               idx    <= '0;
               detect <= 1'b0;
               state  <= SETTLE;
            end
            SETTLE: state <= APPLY;
            APPLY: begin
               idx <= idx + 1'b1;
               if (diff)
                  detect <= 1'b1;
               if (idx == IDX_LAST)
                  state <= NEXT;
`ifdef LBIST_EARLY_EXIT_EN
               if (diff)
                  state <= NEXT;
`endif
            end
            NEXT: begin
               if (fault_cnt != '1)
                  fault_cnt <= fault_cnt + 1'b1;
               if (detect && (detect_cnt != '1))
                  detect_cnt <= detect_cnt + 1'b1;
               state <= bus.fil_end ? DONE : INJECT;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy       = (state != IDLE) && (state != DONE);
   assign bus.done       = (state == DONE);
   assign bus.fil_inc    = (state == INJECT);
   assign bus.test_ip    = pattern;
   assign bus.fault_cnt  = fault_cnt;
   assign bus.detect_cnt = detect_cnt;
   assign bus.mismatch   = mismatch;
endmodule

// File: tb/tb_lbist_ctrl.sv
// Scoreboard bench for lbist_ctrl: two instances (16-bit counters/seed 1 and
// 2-bit counters/seed 0) driven by a FIL + CUT stub model.
module tb_lbist_ctrl;
   import lbist_pkg::*;

   localparam int PAT = 8;
`ifdef LBIST_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lbist_ctrl_if #(.IN_BITS(33), .OUT_BITS(25), .CNT_W(16)) bus_a ();
   lbist_ctrl_if #(.IN_BITS(33), .OUT_BITS(25), .CNT_W(2))  bus_b ();

   lbist_ctrl #(.IN_BITS(33), .OUT_BITS(25), .PAT_CNT(PAT), .CNT_W(16),
                .TAPS(33'h1_0008_0000), .SEED(33'd1))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));

   lbist_ctrl #(.IN_BITS(33), .OUT_BITS(25), .PAT_CNT(PAT), .CNT_W(2),
                .TAPS(33'h1_0008_0000), .SEED(33'd0))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   // scenario knobs shared by both stubs (only one DUT runs at a time)
   int          nf    = 4;
   logic [15:0] mask  = '0;
   int          fpat  = 5;
   int          fbase_a = 0, fbase_b = 0;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int inc_cnt [2] = '{0, 0};
   logic [32:0] ref_seq [PAT];

   typedef struct {
      int id; int fcnt; int dcnt; int cycles; int nf; int start_cyc; int inc_base;
   } exp_t;
   exp_t sbq[$];

   // FIL model: counts injected faults, tracks position since the last fil_inc
   int fno_a, pos_a, fno_b, pos_b, cur_a, cur_b;
   logic flip_a, flip_b, diff_a, diff_b;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         fno_a <= 0; pos_a <= 1000; fno_b <= 0; pos_b <= 1000;
      end else begin
         if (bus_a.fil_inc) begin fno_a <= fno_a + 1; pos_a <= 0; end
         else pos_a <= pos_a + 1;
         if (bus_b.fil_inc) begin fno_b <= fno_b + 1; pos_b <= 0; end
         else pos_b <= pos_b + 1;
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus_a.fil_inc) inc_cnt[0] <= inc_cnt[0] + 1;
      if (bus_b.fil_inc) inc_cnt[1] <= inc_cnt[1] + 1;
   end

   assign cur_a = fno_a - fbase_a;
   assign cur_b = fno_b - fbase_b;
   assign flip_a = bus_a.busy && (pos_a == fpat) && (cur_a >= 1) && (cur_a <= 15) && mask[cur_a[3:0]];
   assign flip_b = bus_b.busy && (pos_b == fpat) && (cur_b >= 1) && (cur_b <= 15) && mask[cur_b[3:0]];
   assign bus_a.ff_op   = bus_a.test_ip[24:0] ^ bus_a.test_ip[32:8];
   assign bus_b.ff_op   = bus_b.test_ip[24:0] ^ bus_b.test_ip[32:8];
   assign bus_a.cut_op  = bus_a.ff_op ^ 25'(flip_a);
   assign bus_b.cut_op  = bus_b.ff_op ^ 25'(flip_b);
   assign bus_a.fil_end = (cur_a == nf);
   assign bus_b.fil_end = (cur_b == nf);
   assign diff_a = (bus_a.cut_op != bus_a.ff_op);
   assign diff_b = (bus_b.cut_op != bus_b.ff_op);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // monitor state
   logic done_prev [2] = '{1'b0, 1'b0};
   logic diff_prev [2] = '{1'b0, 1'b0};

   task automatic mon(input int id, input logic busy, input logic done, input logic mm,
                      input logic [32:0] tip, input logic [15:0] fc, input logic [15:0] dc,
                      input int pos, input int cur, input logic diff);
      bit   flipped;
      int   lim;
      exp_t e;
      flipped = (cur >= 1) && (cur <= 15) && mask[cur[3:0]];
      lim = (EARLY && flipped) ? fpat : PAT;
      if (busy && pos >= 1 && pos <= lim)
         chk($sformatf("test_ip[%0d] pat%0d", id, pos), 64'(tip), 64'(ref_seq[pos-1]));
      chk($sformatf("mismatch[%0d]", id), 64'(mm), 64'(diff_prev[id]));
      chk($sformatf("invariant[%0d]", id), 64'(dc <= fc), 64'(1));
      diff_prev[id] = rst ? diff : 1'b0;
      if (done && !done_prev[id]) begin
         if (sbq.size() == 0 || sbq[0].id != id) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_done: dut %0d raised done with no matching expectation", id);
         end else begin
            e = sbq.pop_front();
            chk($sformatf("fault_cnt[%0d]", id), 64'(fc), 64'(e.fcnt));
            chk($sformatf("detect_cnt[%0d]", id), 64'(dc), 64'(e.dcnt));
            chk($sformatf("cycles[%0d]", id), 64'(cyc - e.start_cyc), 64'(e.cycles));
            chk($sformatf("fil_inc_pulses[%0d]", id), 64'(inc_cnt[id] - e.inc_base), 64'(e.nf));
            $display("campaign dut=%0d faults=%0d detected=%0d cycles=%0d (expected %0d/%0d/%0d)",
                     id, fc, dc, cyc - e.start_cyc, e.fcnt, e.dcnt, e.cycles);
         end
      end
      done_prev[id] = done;
   endtask

   always @(negedge clk) begin
      mon(0, bus_a.busy, bus_a.done, bus_a.mismatch, bus_a.test_ip,
          bus_a.fault_cnt, bus_a.detect_cnt, pos_a, cur_a, diff_a);
      mon(1, bus_b.busy, bus_b.done, bus_b.mismatch, bus_b.test_ip,
          16'(bus_b.fault_cnt), 16'(bus_b.detect_cnt), pos_b, cur_b, diff_b);
   end

   task automatic chk_zero(input int id, input string tag);
      if (id == 0) begin
         chk({tag, " busy"}, 64'(bus_a.busy), 0);
         chk({tag, " done"}, 64'(bus_a.done), 0);
         chk({tag, " fil_inc"}, 64'(bus_a.fil_inc), 0);
         chk({tag, " mismatch"}, 64'(bus_a.mismatch), 0);
         chk({tag, " test_ip"}, 64'(bus_a.test_ip), 0);
         chk({tag, " fault_cnt"}, 64'(bus_a.fault_cnt), 0);
         chk({tag, " detect_cnt"}, 64'(bus_a.detect_cnt), 0);
      end else begin
         chk({tag, " busy"}, 64'(bus_b.busy), 0);
         chk({tag, " done"}, 64'(bus_b.done), 0);
         chk({tag, " test_ip"}, 64'(bus_b.test_ip), 0);
         chk({tag, " fault_cnt"}, 64'(bus_b.fault_cnt), 0);
         chk({tag, " detect_cnt"}, 64'(bus_b.detect_cnt), 0);
      end
   endtask

   // Issue one campaign; expectation computed from fault list, flip mask and pattern
   task automatic run(input int id, input int nf_i, input logic [15:0] mask_i,
                      input int fpat_i, input bit poke, input bit rel_rst);
      exp_t e;
      int   mx, det, cycles;
      mx = (id == 0) ? 65535 : 3;
      det = 0; cycles = 0;
      for (int f = 1; f <= nf_i; f++) begin
         if (mask_i[f]) begin
            det++;
            cycles += EARLY ? fpat_i + 3 : PAT + 3;
         end else begin
            cycles += PAT + 3;
         end
      end
      e.id = id; e.nf = nf_i; e.cycles = cycles;
      e.fcnt = (nf_i < mx) ? nf_i : mx;
      e.dcnt = (det < mx) ? det : mx;
      @(posedge clk); #1;
      nf = nf_i; mask = mask_i; fpat = fpat_i;
      if (id == 0) begin fbase_a = fno_a; bus_a.start = 1'b1; end
      else begin fbase_b = fno_b; bus_b.start = 1'b1; end
      if (rel_rst) rst = 1'b1;
      @(posedge clk); #1;
      e.start_cyc = cyc; e.inc_base = inc_cnt[id];
      sbq.push_back(e);
      bus_a.start = 1'b0; bus_b.start = 1'b0;
      if (poke) begin
         repeat (15) @(posedge clk);
         #1 if (id == 0) bus_a.start = 1'b1; else bus_b.start = 1'b1;
         repeat (3) @(posedge clk);
         #1 begin bus_a.start = 1'b0; bus_b.start = 1'b0; end
      end
      for (int k = 0; k < 3000 && sbq.size() > 0; k++) @(negedge clk);
      if (sbq.size() > 0) begin
         n_chk++; n_fail++;
         $display("FAIL campaign_timeout: dut %0d done not seen within 3000 cycles", id);
         sbq.delete();
      end
      repeat (3) @(negedge clk);
      if (id == 0) begin
         chk("done_hold[0]", 64'(bus_a.done), 1);
         chk("fault_cnt_hold[0]", 64'(bus_a.fault_cnt), 64'(e.fcnt));
      end else begin
         chk("done_hold[1]", 64'(bus_b.done), 1);
         chk("fault_cnt_hold[1]", 64'(bus_b.fault_cnt), 64'(e.fcnt));
      end
   endtask

   initial begin
      logic [32:0] s;
      bit found;
      rst = 1'b0;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      // reference pattern list: seed 1 (seed 0 behaves the same), stepped before use
      s = 33'd1;
      for (int k = 0; k < PAT; k++) begin
         s = {s[31:0], 1'($countones(s & 33'h1_0008_0000) % 2)};
         ref_seq[k] = s;
      end

      repeat (3) @(posedge clk);
      #1 chk_zero(0, "reset_a");
      chk_zero(1, "reset_b");
      @(posedge clk); #1 rst = 1'b1;

      // fault-free campaign: 4 faults, no detections
      run(0, 4, 16'h0000, 5, 1'b0, 1'b0);
      // faults 1 and 3 flip on pattern 5; start pokes while busy are ignored
      run(0, 4, 16'h000A, 5, 1'b1, 1'b0);

      // reset during APPLY of fault 2
      @(posedge clk); #1;
      nf = 4; mask = '0; fpat = 5; fbase_a = fno_a; bus_a.start = 1'b1;
      @(posedge clk); #1 bus_a.start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         if (cur_a == 2 && pos_a == 3) begin found = 1'b1; break; end
      end
      if (!found) begin
         n_chk++; n_fail++;
         $display("FAIL reset_wait: fault 2 APPLY not reached");
      end
      rst = 1'b0;
      #1 chk_zero(0, "async_reset");
      @(negedge clk);
      chk_zero(0, "reset_next_cycle");
      repeat (2) @(posedge clk);
      // start held while reset releases: start seen on first clock
      run(0, 4, 16'h0000, 5, 1'b0, 1'b1);

      // saturation on 2-bit counters with seed 0, every fault detected
      run(1, 6, 16'h007E, 5, 1'b0, 1'b0);
      run(1, 6, 16'h007E, PAT, 1'b0, 1'b0);

      // randomized fault lists and detection patterns
      for (int r = 0; r < 5; r++)
         run(0, int'($urandom_range(1, 8)), 16'($urandom) & 16'h01FE,
             int'($urandom_range(1, PAT)), 1'b0, 1'b0);

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
